// File: rtl/stream_loader.sv
// stream_loader: packs a valid/ready byte stream into little-endian SIZE_1-bit words and writes them to picture or weight RAM.
module stream_loader #(
  parameter int SIZE_1 = 12,
  parameter int PIC_WORDS = 784,
  parameter int WEI_WORDS = 4500,
  localparam int BYTES = (SIZE_1 + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sel,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SIZE_1-1:0] data,
  output logic [12:0]       address,
  output logic              we_p,
  output logic              we_w,
  output logic              re_RAM,
  output logic              busy,
  output logic              done
);
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
  state_t r_state, w_next;
  logic r_sel, r_pend, r_pic, r_we_p, r_we_w, r_re, r_done;
  logic [BW-1:0] r_bcnt;
  logic [12:0] r_wcnt, r_addr;
  logic [8*BYTES-1:0] r_asm, w_asm;
  logic [SIZE_1-1:0] r_data;
  logic w_acc, w_last_byte, w_last_word;
  assign in_ready = r_state == LOAD && !r_pend;
  assign busy = r_state != IDLE;
  assign w_acc = in_valid && in_ready;
  assign w_last_byte = r_bcnt == BW'(BYTES - 1);
  assign w_last_word = r_wcnt == (r_sel ? 13'(WEI_WORDS - 1) : 13'(PIC_WORDS - 1));
  assign data = r_data;
  assign address = r_addr;
  assign we_p = r_we_p;
  assign we_w = r_we_w;
  assign re_RAM = r_re;
  assign done = r_done;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (start ? LOAD : IDLE) :
             r_state == LOAD ? (r_pend ? FINISH : LOAD) : IDLE;
    w_asm = r_asm;
    for (int k = 0; k < BYTES; k++)
      if (BW'(k) == r_bcnt) w_asm[8*k +: 8] = in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= 1'b0;
      r_pend <= 1'b0;
      r_pic <= 1'b0;
      r_we_p <= 1'b0;
      r_we_w <= 1'b0;
      r_re <= 1'b0;
      r_done <= 1'b0;
      r_bcnt <= '0;
      r_wcnt <= '0;
      r_addr <= '0;
      r_asm <= '0;
      r_data <= '0;
    end else begin
      r_we_p <= 1'b0;
      r_we_w <= 1'b0;
      r_done <= r_state == LOAD && r_pend;
      if (r_state == IDLE && start) begin
        r_sel <= sel;
        r_bcnt <= '0;
        r_wcnt <= '0;
        r_pend <= 1'b0;
      end
      if (w_acc) begin
        r_asm <= w_asm;
        r_bcnt <= w_last_byte ? '0 : r_bcnt + 1'b1;
        if (w_last_byte) begin
          r_data <= w_asm[SIZE_1-1:0];
          r_addr <= r_wcnt;
          r_we_p <= !r_sel;
          r_we_w <= r_sel;
          r_wcnt <= r_wcnt + 13'd1;
          r_pend <= w_last_word;
        end
      end
      // re_RAM tracks the state we are entering so it rises with busy falling
      if (r_state == FINISH) begin
        r_pend <= 1'b0;
        if (!r_sel) r_pic <= 1'b1;
      end
      r_re <= w_next == IDLE && (r_pic || (r_state == FINISH && !r_sel));
    end
  end
endmodule

// File: tb/tb_stream_loader.sv
// tb_stream_loader: directed stimulus with a strobe scoreboard for stream_loader (SIZE_1=12, 4 picture words, 6 weight words).
module tb_stream_loader;
  logic clk = 1'b0;
  logic rst, start, sel, in_valid, in_ready, we_p, we_w, re_RAM, busy, done;
  logic [7:0] in_data;
  logic [11:0] data;
  logic [12:0] address;
  logic [26:0] sb[$];
  logic [26:0] exp_w;
  int checks = 0, errors = 0, done_cnt = 0;
  bit mon_en = 0;
  stream_loader #(.SIZE_1(12), .PIC_WORDS(4), .WEI_WORDS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .data(data), .address(address),
    .we_p(we_p), .we_w(we_w), .re_RAM(re_RAM), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick;
    if (gap) begin
      in_valid = 1'b0;
      tick;
    end
  endtask
  task automatic push_exp(input logic s, input logic [12:0] a, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] w;
    w = {b1, b0};
    sb.push_back({~s, s, a, w[11:0]});
  endtask
  task automatic send_word(input logic s, input logic [12:0] a, input logic [7:0] b0, input logic [7:0] b1, input bit gap);
    send_byte(b0, gap);
    push_exp(s, a, b0, b1);
    send_byte(b1, gap);
  endtask
  always @(negedge clk) if (mon_en) begin
    if (done) done_cnt++;
    if (busy) chk("re_during_load", re_RAM, 0);
    if (we_p || we_w) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_strobe: observed we_p=%0b we_w=%0b addr=%0h data=%0h expected none", we_p, we_w, address, data);
      end else begin
        exp_w = sb.pop_front();
        chk("strobe", {we_p, we_w, address, data}, exp_w);
      end
    end
  end
  initial begin
    int stuck;
    rst = 1'b1; start = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick; tick;
    rst = 1'b0;
    mon_en = 1;
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", {in_ready, data, address, we_p, we_w, re_RAM, busy, done}, 0);
      tick;
    end
    // picture load, back-to-back bytes
    in_valid = 1'b0;
    start = 1'b1; sel = 1'b0;
    tick;
    start = 1'b0;
    chk("start_busy_ready", {busy, in_ready}, 2'b11);
    send_word(0, 0, 8'h34, 8'h12, 0);
    send_word(0, 1, 8'hFF, 8'h0F, 0);
    send_word(0, 2, 8'h00, 8'h08, 0);
    send_word(0, 3, 8'h01, 8'h00, 0);
    chk("pic_last_strobe", {we_p, we_w, in_ready, done}, 4'b1000);
    tick;
    in_valid = 1'b0;
    chk("pic_finish", {done, busy, re_RAM}, 3'b110);
    tick;
    chk("pic_idle", {done, busy, re_RAM}, 3'b001);
    chk("pic_done_cnt", done_cnt, 1);
    // weight load, toggled valid, stray start mid-load
    start = 1'b1; sel = 1'b1;
    tick;
    start = 1'b0;
    chk("wei_start", {busy, in_ready, re_RAM}, 3'b110);
    send_word(1, 0, 8'h10, 8'h01, 1);
    send_word(1, 1, 8'h20, 8'h02, 1);
    start = 1'b1; sel = 1'b0;
    tick;
    start = 1'b0;
    send_word(1, 2, 8'h30, 8'h03, 1);
    send_word(1, 3, 8'hEE, 8'hF7, 1);
    send_word(1, 4, 8'h5A, 8'hA5, 1);
    send_byte(8'h66, 1);
    push_exp(1, 5, 8'h66, 8'h09);
    send_byte(8'h09, 0);
    in_valid = 1'b0;
    chk("wei_last_strobe", {we_p, we_w, in_ready}, 3'b010);
    tick;
    chk("wei_finish", {done, busy, re_RAM}, 3'b110);
    tick;
    chk("wei_idle", {done, busy, re_RAM}, 3'b001);
    chk("wei_done_cnt", done_cnt, 2);
    // picture load aborted by reset
    start = 1'b1; sel = 1'b0;
    tick;
    start = 1'b0;
    send_word(0, 0, 8'h01, 8'h01, 0);
    send_word(0, 1, 8'h02, 8'h02, 0);
    send_word(0, 2, 8'h03, 8'h03, 0);
    send_byte(8'h04, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick;
    chk("rst_idle", {busy, in_ready, re_RAM, done, we_p, we_w}, 0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    repeat (5) tick;
    chk("rst_after", {busy, re_RAM, done}, 0);
    chk("rst_done_cnt", done_cnt, 2);
    // fresh picture load with a long mid-word stall
    in_valid = 1'b0;
    start = 1'b1; sel = 1'b0;
    tick;
    start = 1'b0;
    send_byte(8'hAB, 0);
    in_valid = 1'b0;
    stuck = 0;
    repeat (50) begin
      tick;
      if (busy) stuck++;
    end
    chk("hold_busy", stuck, 50);
    push_exp(0, 0, 8'hAB, 8'h05);
    send_byte(8'h05, 0);
    send_word(0, 1, 8'h11, 8'h02, 0);
    send_word(0, 2, 8'h22, 8'h03, 0);
    send_word(0, 3, 8'hC0, 8'hFF, 0);
    in_valid = 1'b0;
    tick;
    chk("fresh_done", done, 1);
    tick;
    chk("fresh_idle", {busy, re_RAM}, 2'b01);
    chk("fresh_done_cnt", done_cnt, 3);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
